// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer: mode codes, command
// layout, FSM states and the per-mode LED decode.
package led_seq_pkg;

    localparam logic [2:0] MODE_OFF      = 3'd0;
    localparam logic [2:0] MODE_ROT_UP   = 3'd1;
    localparam logic [2:0] MODE_ROT_DOWN = 3'd2;
    localparam logic [2:0] MODE_BOUNCE   = 3'd3;
    localparam logic [2:0] MODE_BLINK    = 3'd4;
    localparam logic [2:0] MODE_ALL_ON   = 3'd5;

    localparam int CMD_MODE_LSB = 0;
    localparam int CMD_SPD_LSB  = 3;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_STEP  = 2'd1,
        ST_LOAD  = 2'd2
    } led_state_t;

    typedef struct packed {
        logic [1:0] spd;
        logic [2:0] mode;
    } led_cmd_t;

    // Ring LEDs from (mode, position, blink phase); centre LED lights for any non-OFF mode.
    function automatic logic [4:0] led_pattern(input logic [2:0] m,
                                               input logic [1:0] pos,
                                               input logic       phase);
        logic [3:0] ring;
        case (m)
            MODE_ROT_UP, MODE_ROT_DOWN, MODE_BOUNCE: ring = 4'b0001 << pos;
            MODE_BLINK:  ring = {4{phase}};
            MODE_ALL_ON: ring = 4'b1111;
            default:     ring = 4'b0000;
        endcase
        return {m != MODE_OFF, ring};
    endfunction

endpackage

// File: rtl/led_rr_arbiter.sv
// Two-way round-robin arbiter; the pointer names the requester that wins a tie
// and flips to the other requester after every grant.
module led_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       en,
    output logic [1:0] grant
);

    logic rr_q;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = rr_q ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_q <= 1'b0;
        else if (|grant)
            rr_q <= grant[0];
    end

endmodule

// File: rtl/led_sequencer.sv
// Mode/speed-driven LED pattern engine with its own step-rate divider, fed by
// two command sources through a round-robin valid/ready arbiter.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV = 6_000_000,
    parameter int DIV_W    = 23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [4:0] req0_cmd,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [4:0] req1_cmd,
    output logic       req1_ready,
    output logic [4:0] led,
    output logic [2:0] mode
);

    led_state_t       state_q, state_d;
    logic [2:0]       mode_q, mode_d;
    logic [1:0]       spd_q, spd_d;
    logic [1:0]       pos_q, pos_d;
    logic             dir_q, dir_d;      // 0 = counting up
    logic             phase_q, phase_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [4:0]       led_q, led_d;

    logic [1:0]       grant;
    logic             arb_en;
    logic             acc;
    logic             load_acc;
    logic [4:0]       cmd_sel;
    logic [2:0]       cmd_mode;
    logic [1:0]       cmd_spd;
    logic [DIV_W-1:0] div_last;
    logic             wrap;

    assign arb_en = (state_q == ST_STEP);

    led_rr_arbiter u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid ({req1_valid, req0_valid}),
        .en    (arb_en),
        .grant (grant)
    );

    assign req0_ready = arb_en & grant[0];
    assign req1_ready = arb_en & grant[1];
    assign acc        = req0_ready | req1_ready;

    assign cmd_sel  = grant[1] ? req1_cmd : req0_cmd;
    assign cmd_mode = cmd_sel[CMD_MODE_LSB +: 3];
    assign cmd_spd  = cmd_sel[CMD_SPD_LSB +: 2];
    // Reserved codes complete the handshake but never disturb the running pattern.
    assign load_acc = acc & (cmd_mode <= MODE_ALL_ON);

    assign div_last = DIV_W'((32'(TICK_DIV) >> spd_q) - 32'd1);
    assign wrap     = (div_q == div_last);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        spd_d   = spd_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        phase_d = phase_q;
        div_d   = div_q;
        led_d   = led_q;
        case (state_q)
            ST_RESET: state_d = ST_STEP;
            ST_STEP: begin
                if (load_acc) begin
                    // An accepted mode pre-empts a step firing in the same cycle.
                    mode_d  = cmd_mode;
                    spd_d   = cmd_spd;
                    div_d   = '0;
                    state_d = ST_LOAD;
                end else begin
                    div_d = wrap ? '0 : div_q + 1'b1;
                    if (wrap) begin
                        case (mode_q)
                            MODE_ROT_UP:   pos_d = pos_q + 2'd1;
                            MODE_ROT_DOWN: pos_d = pos_q - 2'd1;
                            MODE_BOUNCE: begin
                                pos_d = dir_q ? pos_q - 2'd1 : pos_q + 2'd1;
                                if (pos_d == 2'd3)
                                    dir_d = 1'b1;
                                else if (pos_d == 2'd0)
                                    dir_d = 1'b0;
                            end
                            MODE_BLINK:    phase_d = ~phase_q;
                            default:       pos_d = pos_q;
                        endcase
                        led_d = led_pattern(mode_q, pos_d, phase_d);
                    end
                end
            end
            ST_LOAD: begin
                pos_d   = 2'd0;
                dir_d   = 1'b0;
                phase_d = 1'b0;
                div_d   = '0;
                led_d   = led_pattern(mode_q, 2'd0, 1'b0);
                state_d = ST_STEP;
            end
            default: state_d = ST_STEP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RESET;
            mode_q  <= MODE_OFF;
            spd_q   <= 2'd0;
            pos_q   <= 2'd0;
            dir_q   <= 1'b0;
            phase_q <= 1'b0;
            div_q   <= '0;
            led_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            spd_q   <= spd_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            phase_q <= phase_d;
            div_q   <= div_d;
            led_q   <= led_d;
        end
    end

    assign led  = led_q;
    assign mode = mode_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Randomized and directed bench for led_sequencer; expectations come from a
// time-based model (pattern index = elapsed steps since the last load).
module tb_led_sequencer;

    localparam int TICK_DIV = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [4:0] req0_cmd = 5'd0, req1_cmd = 5'd0;
    logic       req0_ready, req1_ready;
    logic [4:0] led;
    logic [2:0] mode;

    led_sequencer #(.TICK_DIV(TICK_DIV), .DIV_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_cmd   (req0_cmd),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_cmd   (req1_cmd),
        .req1_ready (req1_ready),
        .led        (led),
        .mode       (mode)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Requester drive state
    logic       v0 = 1'b0, v1 = 1'b0;
    logic [4:0] c0 = 5'd0, c1 = 5'd0;
    bit         acc0, acc1;   // DUT accepted this cycle

    // Reference model: e counts clock edges since reset release; m_n is the
    // edge where the running mode was accepted.
    int         e;
    int         m_n;
    bit         m_act;
    bit         m_rst_st;
    bit         m_rr;
    int         m_mode, m_spd;
    logic [4:0] m_prev;
    int         bseq [6] = '{0, 1, 2, 3, 2, 1};

    function automatic logic [4:0] exp_led();
        int k, p;
        logic [3:0] ring;
        logic [3:0] one;
        if (!m_act) return 5'd0;
        if (e == m_n) return m_prev;
        k = (e - m_n - 1) / (TICK_DIV >> m_spd);
        one = 4'b0001;
        case (m_mode)
            1: ring = one << (k % 4);
            2: ring = one << ((4 - (k % 4)) % 4);
            3: ring = one << bseq[k % 6];
            4: ring = (k % 2 == 1) ? 4'b1111 : 4'b0000;
            5: ring = 4'b1111;
            default: ring = 4'b0000;
        endcase
        p = (m_mode != 0) ? 1 : 0;
        return {p[0], ring};
    endfunction

    function automatic logic [1:0] exp_ready();
        if (m_rst_st || e == m_n) return 2'b00;
        if (v0 && v1) return m_rr ? 2'b10 : 2'b01;
        return {v1, v0};
    endfunction

    task automatic model_reset();
        e = 0; m_n = -100; m_act = 0; m_rst_st = 1; m_rr = 0;
        m_mode = 0; m_spd = 0; m_prev = 5'd0;
    endtask

    // One clock: drive at negedge, check 1 time unit later, advance model over the edge.
    task automatic run_cycle();
        logic [1:0] er;
        logic [4:0] cm;
        req0_valid = v0; req0_cmd = c0;
        req1_valid = v1; req1_cmd = c1;
        #1;
        er = exp_ready();
        check("ready0", 32'(req0_ready), 32'(er[0]));
        check("ready1", 32'(req1_ready), 32'(er[1]));
        check("led", 32'(led), 32'(exp_led()));
        check("mode", 32'(mode), 32'(m_mode));
        acc0 = req0_ready & v0;
        acc1 = req1_ready & v1;
        if (er != 2'b00) begin
            m_rr = er[0];
            cm = er[0] ? c0 : c1;
            if (cm[2:0] <= 3'd5) begin
                m_prev = exp_led();
                m_mode = int'(cm[2:0]);
                m_spd  = int'(cm[4:3]);
                m_n    = e + 1;
                m_act  = 1;
            end
        end
        e++;
        m_rst_st = 0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    task automatic send(input int who, input logic [4:0] cmd);
        bit done = 0;
        if (who == 0) begin v0 = 1; c0 = cmd; end
        else          begin v1 = 1; c1 = cmd; end
        for (int i = 0; i < 40 && !done; i++) begin
            run_cycle();
            done = (who == 0) ? acc0 : acc1;
        end
        check("send_accept", 32'(done), 32'd1);
        if (who == 0) v0 = 0; else v1 = 0;
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        req0_valid = 1'b1; req0_cmd = 5'd1;
        req1_valid = 1'b1; req1_cmd = 5'd4;
        for (int i = 0; i < n; i++) begin
            #1;
            check("rst_led", 32'(led), 32'd0);
            check("rst_mode", 32'(mode), 32'd0);
            check("rst_ready0", 32'(req0_ready), 32'd0);
            check("rst_ready1", 32'(req1_ready), 32'd0);
            @(negedge clk);
        end
        rst = 1'b0;
        v0 = 0; v1 = 0;
        model_reset();
    endtask

    initial begin
        int exp_who, last_g, gap, ngr;
        bit p0, p1;
        model_reset();
        @(negedge clk);
        apply_reset(3);

        // ROT_UP at speed 0
        send(0, {2'd0, 3'd1});
        idle(16 * 5 + 2);

        // BOUNCE at speed 2
        send(1, {2'd2, 3'd3});
        idle(36);

        // Both requesters valid every cycle
        apply_reset(2);
        v0 = 1; c0 = {2'd1, 3'd2};
        v1 = 1; c1 = {2'd1, 3'd4};
        exp_who = 0; last_g = -1; ngr = 0;
        for (int i = 0; i < 14; i++) begin
            run_cycle();
            if (acc0 || acc1) begin
                check("alt_who", acc1 ? 32'd1 : 32'd0, 32'(exp_who));
                if (last_g >= 0) begin
                    gap = i - last_g;
                    check("alt_gap", 32'(gap), 32'd2);
                end
                exp_who ^= 1; last_g = i; ngr++;
            end
        end
        check("alt_count", 32'(ngr >= 5), 32'd1);
        v0 = 0; v1 = 0;
        idle(4);

        // Reserved mode 7 during BLINK
        send(0, {2'd1, 3'd4});
        idle(13);
        send(1, {2'd0, 3'd7});
        check("rsv_mode", 32'(mode), 32'd4);
        idle(30);

        // Command landing on the step-fire edge
        send(0, {2'd0, 3'd1});
        idle(TICK_DIV);
        send(1, {2'd1, 3'd2});
        idle(20);

        // Reset mid-ROT_UP
        send(0, {2'd0, 3'd1});
        idle(21);
        apply_reset(3);
        idle(4);
        send(0, {2'd3, 3'd4});
        idle(10);

        // Random traffic
        p0 = 0; p1 = 0;
        for (int i = 0; i < 1200; i++) begin
            if (!p0 && $urandom_range(0, 3) == 0) begin p0 = 1; c0 = 5'($urandom_range(0, 31)); end
            if (!p1 && $urandom_range(0, 3) == 0) begin p1 = 1; c1 = 5'($urandom_range(0, 31)); end
            v0 = p0; v1 = p1;
            run_cycle();
            if (acc0) p0 = 0;
            if (acc1) p1 = 0;
            v0 = p0; v1 = p1;
            if ($urandom_range(0, 299) == 0) begin
                apply_reset(2);
                p0 = 0; p1 = 0;
            end
        end
        v0 = 0; v1 = 0;
        idle(40);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
